// File: rtl/main_ram_arbiter.sv
// Three-port fixed-priority arbiter for the single-port main RAM, with an
// anti-starvation override that lifts the host port (2) to top priority.
module main_ram_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [44:0] addr,
    input  logic [2:0]  write,
    input  logic [95:0] wrdata,
    input  logic [11:0] wrbytesel,
    output logic [2:0]  ack,
    output logic [2:0]  rvalid,
    output logic [31:0] rddata,
    output logic [14:0] bus_addr,
    output logic [31:0] bus_wrdata,
    output logic [3:0]  bus_wrbytesel,
    output logic        bus_write,
    input  logic [31:0] bus_rddata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] rvalid_q, rvalid_d;
    logic       starve;

    assign starve = (wait_cnt_q == MAX_WAIT_C);

    always_comb begin
        ack = 3'b000;
        if (starve && req[2]) begin
            ack = 3'b100;
        end else if (req[0]) begin
            ack = 3'b001;
        end else if (req[1]) begin
            ack = 3'b010;
        end else if (req[2]) begin
            ack = 3'b100;
        end
    end

    // ack is one-hot, so OR-ing the masked port fields selects the winner
    always_comb begin
        bus_addr      = '0;
        bus_wrdata    = '0;
        bus_wrbytesel = '0;
        bus_write     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ack[i]) begin
                bus_addr      = bus_addr      | addr[15*i +: 15];
                bus_wrdata    = bus_wrdata    | wrdata[32*i +: 32];
                bus_wrbytesel = bus_wrbytesel | wrbytesel[4*i +: 4];
                bus_write     = bus_write     | write[i];
            end
        end
    end

    always_comb begin
        rvalid_d   = ack & ~write;
        wait_cnt_d = 8'd0;
        if (req[2] && !ack[2]) begin
            wait_cnt_d = starve ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            rvalid_q   <= 3'b000;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // RAM output is already registered, so read data passes straight through
    assign rvalid = rvalid_q;
    assign rddata = bus_rddata;

endmodule

// File: doc/main_ram_arbiter.md
# main_ram_arbiter

Three-port arbiter sharing the single-port 32-bit main RAM (32K words × 32 bits, byte-write, one-cycle registered read) between the sprite fetcher (port 0), the layer renderer (port 1) and the host/CPU access path (port 2). It grants at most one access per clock using fixed priority with an anti-starvation override for port 2. It drives the RAM slave bus and routes read data back, with a per-port valid strobe. It sits between the requesters and the main RAM instance.

## Interface
- MAX_WAIT, 8: number of consecutive blocked cycles of port 2 after which port 2 takes top priority (1..255).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  3  per-port access request; bit i = port i.
- addr  input  45  word addresses; port i at [15i+14:15i].
- write  input  3  per-port write flag (1 = write, 0 = read).
- wrdata  input  96  write data; port i at [32i+31:32i].
- wrbytesel  input  12  byte enables; port i at [4i+3:4i].
- ack  output  3  one-hot combinational grant; access accepted this cycle.
- rvalid  output  3  one-hot registered; read data for port i valid this cycle.
- rddata  output  32  read data, shared by all ports; qualified by rvalid.
- bus_addr  output  15  RAM word address.
- bus_wrdata  output  32  RAM write data.
- bus_wrbytesel  output  4  RAM byte enables.
- bus_write  output  1  RAM write strobe.
- bus_rddata  input  32  RAM read data (valid one cycle after address).

## Operation
- Priority each cycle: if starve flag set and req[2], grant port 2; else lowest-numbered requesting port (0 > 1 > 2).
- ack = one-hot of the granted port; all zero when req == 0.
- Granted port's addr/wrdata/wrbytesel/write drive the bus. No grant: bus_addr = 0, bus_wrdata = 0, bus_wrbytesel = 0, bus_write = 0.
- bus_write = write[g] for the granted port g; wrbytesel passes unmodified (RAM gates it with bus_write).
- Requester holds req, addr, write, wrdata, wrbytesel stable until it sees ack high. It may drop req after ack or keep it high for back-to-back accesses (a new access each acked cycle).
- Read return: on the cycle after an acked read by port i, rvalid[i] = 1 and rddata = bus_rddata. Writes never raise rvalid.
- Starvation counter wait_cnt (8 bits):
  - increments, saturating at MAX_WAIT, while req[2] & ~ack[2];
  - clears when ack[2] or ~req[2].
  - starve = (wait_cnt == MAX_WAIT).
- Ports 0 and 1 have no starvation guard; their clients bound their own duty cycle.
- Reset:
  - rvalid = 0, wait_cnt = 0.
  - ack and bus_* are combinational and follow inputs (all zero while req = 0).
  - Reset asserted mid-operation drops any pending read return: no rvalid after reset release for accesses acked before reset.

## Timing
- Cycle N: req[i] high, granted → ack[i] = 1 combinationally; bus driven in cycle N; write lands at edge N→N+1.
- Cycle N+1: rvalid[i] = 1 for reads, rddata = RAM word. Read-to-data latency is 1 cycle. Throughput is 1 access per cycle total.
- Read of an address written in the previous cycle returns the new data (write-first RAM, separate cycles).
- Port 2 worst-case wait with continuous port 0/1 traffic: MAX_WAIT blocked cycles, then granted in cycle MAX_WAIT+1.
- Simultaneous req on all three ports with starve = 0: port 0 wins. Next cycle, if req persists, port 0 wins again.
- rvalid is never asserted on two ports in the same cycle.

## Test plan
- Reset: rst_n low with random inputs → rvalid = 0. After release with req = 0: ack = 0, bus_write = 0, bus_addr = 0.
- Single port 1 write then read: addr 0x1234, wrdata 0xDEADBEEF, wrbytesel 4'b1111, then read → ack[1] each cycle; read returns rvalid[1] = 1 with rddata 0xDEADBEEF one cycle after the read ack.
- Byte write: write 0x00000000 to addr 5, then wrbytesel 4'b0100 with data 0x00AB0000, then read → rddata 0x00AB0000.
- Priority: req = 3'b111 for 1 cycle → ack = 3'b001. With req = 3'b110 → ack = 3'b010. rvalid follows the winner only.
- Starvation: MAX_WAIT = 4, req[0] held high continuously with req[2] high → ack[2] rises exactly on the 5th cycle, wait_cnt then clears, and port 0 resumes on the following cycle.
- Reset mid-read: port 0 read acked in cycle N, rst_n low in the same cycle → rvalid stays 0 through and after reset release.
